gate_stim_seq: RTL
==================

// Module: gate_stim_seq
// PURPOSE
//  Upstream stimulus sequencer for the 2-input basic-gate block. On start, it
//  drives a1/a2 through 00,01,10,11, holding each vector DWELL cycles, for LOOPS passes.
//  Optionally, it checks the gate block's 7 outputs against expected values and
//  counts mismatches.
//  Replaces hand-written #delay stimulus so the gate block can be exercised in a clocked system.
// PARAMETERS
//  DWELL  20  cycles each vector is held; legal range 1..65535
//  LOOPS  1   full 4-vector passes per start; legal range 1..255
//  ERR_W  8   width of err_cnt
// PORTS
//  clk       in   1      single clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      1-cycle request to begin a run
//  busy      out  1      high while vectors are being driven
//  done      out  1      1-cycle pulse after the final vector's last dwell cycle
//  a1        out  1      stimulus to gate block (MSB of vector index)
//  a2        out  1      stimulus to gate block (LSB of vector index)
//  vec_stb   out  1      1-cycle pulse on the first cycle of each new vector
//  y_in      in   7      gate outputs: [0]~a1 [1]and [2]nand [3]or [4]nor [5]xor [6]xnor
//  err_cnt   out  ERR_W  mismatch count (optional feature only; else tied 0)
//  err_flag  out  1      sticky: err_cnt != 0 (optional feature only; else 0)
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; a1=a2=0; busy=done=vec_stb=0;
//    err_cnt=0; err_flag=0; dwell, vector and loop counters = 0.
//  - FSM states: IDLE -> RUN -> FIN -> IDLE.
//  - IDLE: start=1 -> RUN on the next edge. That edge sets busy=1, vec_idx=0,
//    a1a2=00 and vec_stb=1. It also clears err_cnt/err_flag.
//  - RUN: dwell counter counts 0..DWELL-1. At DWELL-1:
//    - if vec_idx<3: vec_idx++ and vec_stb=1 on the next cycle;
//    - else if loop<LOOPS-1: loop++, vec_idx=0, vec_stb=1;
//    - else -> FIN.
//  - FIN: busy=0, done=1 for exactly one cycle, a1a2 return to 00, then -> IDLE.
//  - Timing: a1={vec_idx[1]}, a2={vec_idx[0]}, both registered.
//    Total run from start edge to done = 4*DWELL*LOOPS + 1 cycles.
//  - start while busy or in FIN: ignored; no restart and no queuing.
//  - start in the same cycle done=1: ignored. A new start is needed in IDLE.
//  - DWELL=1: a new vector every cycle; vec_stb is high for 4*LOOPS consecutive cycles.
//  - Dwell counter width: $clog2(DWELL+1). Loop counter: 8 bits.
//  - Reset asserted mid-run aborts immediately: no done pulse, all outputs go to reset values.
// CONFIGURATION
//  - Macro GATE_CHECK_EN.
//  - Defined:
//    - On the last dwell cycle of each vector, y_in is compared to the expected
//      vector computed from the registered a1/a2.
//    - Expected vector = {~(a1^a2), a1^a2, ~(a1|a2), a1|a2, ~(a1&a2), a1&a2, ~a1}.
//    - Each mismatching vector adds 1 to err_cnt, not one per bit. err_cnt saturates at 2^ERR_W-1.
//    - err_flag is set with the first increment and stays set until reset or the next start.
//  - Undefined: no compare logic is built; err_cnt=0 and err_flag=0 constantly.
// TESTING
//  1. Reset then idle: rst pulse mid-cycle -> all outputs 0 asynchronously; no activity without start.
//  2. DWELL=20, LOOPS=1, start:
//     - a1a2 = 00,01,10,11 at cycles 1,21,41,61 (vec_stb at each);
//     - done at cycle 81; busy high for cycles 1..80.
//  3. DWELL=1, LOOPS=2: a1a2 steps every cycle through 8 vectors; done 9 cycles after start.
//  4. start re-pulsed at cycle 30 of a run -> ignored; timing identical to test 2.
//  5. GATE_CHECK_EN, golden gate model on y_in -> err_cnt=0. Force y_in[5]=0 -> err_cnt=2 (vectors 01,10), err_flag=1.
//  6. Assert rst at cycle 45 of a run -> immediate IDLE, no done; a subsequent start runs cleanly from 00.

Source files
------------

// File: rtl/gate_stim_seq.sv
// Purpose : clocked stimulus sequencer for the 2-input basic-gate block; walks a1/a2 through 00,01,10,11.
// Latency : first vector on the edge after start; done pulses 4*DWELL*LOOPS+1 cycles after that start edge.
// Backpres: none; start is a 1-cycle request, ignored unless IDLE (no queuing, no restart).
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           1-cycle run request (honoured in IDLE only)
//   busy            high while vectors are being driven
//   done            1-cycle pulse after the final vector's last dwell cycle
//   a1, a2          registered stimulus (vec_idx[1], vec_idx[0])
//   vec_stb         1-cycle pulse on the first cycle of each vector
//   y_in[6:0]       gate outputs: [0]~a1 [1]and [2]nand [3]or [4]nor [5]xor [6]xnor
//   err_cnt, err_flag  mismatch count / sticky flag (only with GATE_CHECK_EN, else 0)
//
// Optional feature macro: GATE_CHECK_EN (builds the y_in compare and error counter).
module gate_stim_seq #(
  parameter int DWELL = 20,
  parameter int LOOPS = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             a1,
  output logic             a2,
  output logic             vec_stb,
  input  logic [6:0]       y_in,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_flag
);

  localparam int             DW         = $clog2(DWELL + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);
  localparam logic [7:0]     LOOPS_LAST = 8'(LOOPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t        state;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    vec_idx;
  logic [7:0]    loop_cnt;
  logic          last_dwell;

  // vec_idx is a flop, so a1/a2 are registered outputs; it is forced to 0
  // outside RUN so the gate block sees 00 while idle.
  assign a1 = vec_idx[1];
  assign a2 = vec_idx[0];

  assign last_dwell = (state == S_RUN) && (dwell_cnt == DWELL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_stb   <= 1'b0;
      dwell_cnt <= '0;
      vec_idx   <= 2'd0;
      loop_cnt  <= 8'd0;
    end else begin
      vec_stb <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            busy      <= 1'b1;
            vec_stb   <= 1'b1;
            dwell_cnt <= '0;
            vec_idx   <= 2'd0;
            loop_cnt  <= 8'd0;
          end
        end
        S_RUN: begin
          if (last_dwell) begin
            dwell_cnt <= '0;
            if (vec_idx != 2'd3) begin
              vec_idx <= vec_idx + 2'd1;
              vec_stb <= 1'b1;
            end else if (loop_cnt != LOOPS_LAST) begin
              loop_cnt <= loop_cnt + 8'd1;
              vec_idx  <= 2'd0;
              vec_stb  <= 1'b1;
            end else begin
              state   <= S_FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
              vec_idx <= 2'd0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        S_FIN: begin
          // start seen while done is high is dropped here on purpose.
          state    <= S_IDLE;
          loop_cnt <= 8'd0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GATE_CHECK_EN
  logic [6:0] exp_y;
  logic       mismatch;

  always_comb begin
    exp_y = {~(a1 ^ a2), a1 ^ a2, ~(a1 | a2), a1 | a2, ~(a1 & a2), a1 & a2, ~a1};
  end

  // One compare per vector, on its final dwell cycle, so the gate block has
  // had the whole dwell to settle.
  assign mismatch = last_dwell && (y_in != exp_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (mismatch) begin
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
      err_flag <= 1'b1;
    end
  end
`else
  logic unused_y;
  assign unused_y = ^y_in;
  assign err_cnt  = '0;
  assign err_flag = 1'b0;
`endif

endmodule
